// File: rtl/alarm_ringer_if.sv
// rtl/alarm_ringer_if.sv - time/alarm digits, tick/button inputs and ringer outputs
interface alarm_ringer_if;
  logic       ENABLE;
  logic       ENABLE_kHz;
  logic       EN05;
  logic       ALARM_ON;
  logic       SET_MODE;
  logic       BAP_BTN2;
  logic       BAP_BTN3;
  logic [3:0] COUNT_10;
  logic [2:0] COUNT_6;
  logic [3:0] COUNT_10m;
  logic [2:0] COUNT_6m;
  logic [3:0] COUNT_10h;
  logic [1:0] COUNT_2h;
  logic [3:0] ACOUNT_10m;
  logic [2:0] ACOUNT_6m;
  logic [3:0] ACOUNT_10h;
  logic [1:0] ACOUNT_2h;
  logic       ALARM_STATE;
  logic       SNOOZE_LED;
  logic       BUZZER;

  modport master (
    output ENABLE, ENABLE_kHz, EN05, ALARM_ON, SET_MODE, BAP_BTN2, BAP_BTN3,
    output COUNT_10, COUNT_6, COUNT_10m, COUNT_6m, COUNT_10h, COUNT_2h,
    output ACOUNT_10m, ACOUNT_6m, ACOUNT_10h, ACOUNT_2h,
    input  ALARM_STATE, SNOOZE_LED, BUZZER
  );

  modport slave (
    input  ENABLE, ENABLE_kHz, EN05, ALARM_ON, SET_MODE, BAP_BTN2, BAP_BTN3,
    input  COUNT_10, COUNT_6, COUNT_10m, COUNT_6m, COUNT_10h, COUNT_2h,
    input  ACOUNT_10m, ACOUNT_6m, ACOUNT_10h, ACOUNT_2h,
    output ALARM_STATE, SNOOZE_LED, BUZZER
  );
endinterface

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm match, ring/snooze sequencing and gated 500 Hz buzzer
module alarm_ringer #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic          CLK,
  input  logic          RESET,
  alarm_ringer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZE  = 2'd2
  } state_t;

  localparam logic [8:0] RING_LAST = 9'(RING_SEC - 1);
  localparam logic [8:0] SNZ_LAST  = 9'(SNOOZE_SEC - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_match;
  logic       w_trig;
  logic       w_tone_nxt;
  logic       r_match_q;
  logic [8:0] r_ring_cnt;
  logic [8:0] r_snz_cnt;
  logic       r_tone_q;
  logic       r_alarm_state;
  logic       r_snooze_led;
  logic       r_buzzer;

  // hh:mm equal to the alarm and seconds at :00; trigger only on the first cycle of it
  always_comb begin
    w_match = (bus.COUNT_2h  == bus.ACOUNT_2h)  &&
              (bus.COUNT_10h == bus.ACOUNT_10h) &&
              (bus.COUNT_6m  == bus.ACOUNT_6m)  &&
              (bus.COUNT_10m == bus.ACOUNT_10m) &&
              (bus.COUNT_6   == 3'd0)           &&
              (bus.COUNT_10  == 4'd0);
    w_trig  = w_match && !r_match_q && bus.ALARM_ON && !bus.SET_MODE;
  end

  // next-state decision in priority order, plus the tone phase that goes with it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trig) w_state_nxt = S_RINGING;
      end
      S_RINGING: begin
        if (!bus.ALARM_ON)                             w_state_nxt = S_IDLE;
        else if (bus.BAP_BTN3)                         w_state_nxt = S_IDLE;
        else if (bus.BAP_BTN2)                         w_state_nxt = S_SNOOZE;
        else if (bus.ENABLE && r_ring_cnt == RING_LAST) w_state_nxt = S_IDLE;
      end
      S_SNOOZE: begin
        if (!bus.ALARM_ON)                            w_state_nxt = S_IDLE;
        else if (bus.BAP_BTN3)                        w_state_nxt = S_IDLE;
        else if (bus.ENABLE && r_snz_cnt == SNZ_LAST) w_state_nxt = S_RINGING;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // tone starts from 0 on every ring entry and is forced low outside RINGING
    w_tone_nxt = 1'b0;
    if (w_state_nxt == S_RINGING && r_state == S_RINGING)
      w_tone_nxt = r_tone_q ^ bus.ENABLE_kHz;
  end

  // state, second counters, tone and registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= S_IDLE;
      r_match_q     <= 1'b0;
      r_ring_cnt    <= 9'd0;
      r_snz_cnt     <= 9'd0;
      r_tone_q      <= 1'b0;
      r_alarm_state <= 1'b0;
      r_snooze_led  <= 1'b0;
      r_buzzer      <= 1'b0;
    end else begin
      r_match_q <= w_match;
      r_state   <= w_state_nxt;
      r_tone_q  <= w_tone_nxt;

      if (w_state_nxt != r_state) begin
        r_ring_cnt <= 9'd0;
        r_snz_cnt  <= 9'd0;
      end else begin
        if (r_state == S_RINGING && bus.ENABLE && r_ring_cnt != RING_LAST)
          r_ring_cnt <= r_ring_cnt + 9'd1;
        if (r_state == S_SNOOZE && bus.ENABLE && r_snz_cnt != SNZ_LAST)
          r_snz_cnt <= r_snz_cnt + 9'd1;
      end

      r_alarm_state <= (w_state_nxt == S_RINGING);
      r_snooze_led  <= (w_state_nxt == S_SNOOZE);
      r_buzzer      <= (w_state_nxt == S_RINGING) && bus.EN05 && w_tone_nxt;
    end
  end

  assign bus.ALARM_STATE = r_alarm_state;
  assign bus.SNOOZE_LED  = r_snooze_led;
  assign bus.BUZZER      = r_buzzer;

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - vector table, corner sequences and randomized model check for alarm_ringer
module tb_alarm_ringer;
  localparam int RING   = 60;
  localparam int SNOOZE = 300;

  logic CLK = 1'b0;
  logic RESET;
  always #4 CLK = ~CLK;

  alarm_ringer_if bus();

  alarm_ringer #(.RING_SEC(RING), .SNOOZE_SEC(SNOOZE)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int th, tm, ts, ah, am;

  typedef struct {
    bit on, set, hit, b2, b3, en, khz, e05;
    bit es, esn, eb;
  } vec_t;
  vec_t tbl[$];

  // behavioural model: countdown of remaining seconds, count of kHz ticks since ring entry
  bit m_ring, m_snz, m_prev, m_buzz;
  int m_left, m_tones;

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic es, input logic esn, input logic eb);
    check1({name, "/alarm_state"}, bus.ALARM_STATE, es);
    check1({name, "/snooze_led"},  bus.SNOOZE_LED,  esn);
    check1({name, "/buzzer"},      bus.BUZZER,      eb);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    th = h; tm = m; ts = s;
    bus.COUNT_2h  = 2'(h / 10);
    bus.COUNT_10h = 4'(h % 10);
    bus.COUNT_6m  = 3'(m / 10);
    bus.COUNT_10m = 4'(m % 10);
    bus.COUNT_6   = 3'(s / 10);
    bus.COUNT_10  = 4'(s % 10);
  endtask

  task automatic set_alarm(input int h, input int m);
    ah = h; am = m;
    bus.ACOUNT_2h  = 2'(h / 10);
    bus.ACOUNT_10h = 4'(h % 10);
    bus.ACOUNT_6m  = 3'(m / 10);
    bus.ACOUNT_10m = 4'(m % 10);
  endtask

  task automatic cycle(input bit en, input bit khz, input bit b2, input bit b3);
    bus.ENABLE = en; bus.ENABLE_kHz = khz; bus.BAP_BTN2 = b2; bus.BAP_BTN3 = b3;
    @(posedge CLK); #1;
    bus.ENABLE = 0; bus.ENABLE_kHz = 0; bus.BAP_BTN2 = 0; bus.BAP_BTN3 = 0;
  endtask

  task automatic retrig();
    set_time(ah, am, 1);
    cycle(0, 0, 0, 0);
    set_time(ah, am, 0);
    cycle(0, 0, 0, 0);
  endtask

  task automatic model_step();
    bit was_ring, match, trig;
    was_ring = m_ring;
    match = (th == ah) && (tm == am) && (ts == 0);
    trig  = match && !m_prev && bus.ALARM_ON && !bus.SET_MODE;
    m_prev = match;
    if (!bus.ALARM_ON) begin
      m_ring = 0; m_snz = 0;
    end else if (m_ring) begin
      if (bus.BAP_BTN3) m_ring = 0;
      else if (bus.BAP_BTN2) begin m_ring = 0; m_snz = 1; m_left = SNOOZE; end
      else if (bus.ENABLE) begin m_left--; if (m_left == 0) m_ring = 0; end
    end else if (m_snz) begin
      if (bus.BAP_BTN3) m_snz = 0;
      else if (bus.ENABLE) begin
        m_left--;
        if (m_left == 0) begin m_snz = 0; m_ring = 1; m_left = RING; end
      end
    end else if (trig) begin
      m_ring = 1; m_left = RING;
    end
    if (was_ring && m_ring) m_tones += int'(bus.ENABLE_kHz);
    else m_tones = 0;
    m_buzz = m_ring && bus.EN05 && (m_tones % 2 == 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    bus.ENABLE = 0; bus.ENABLE_kHz = 0; bus.EN05 = 0; bus.ALARM_ON = 1;
    bus.SET_MODE = 0; bus.BAP_BTN2 = 0; bus.BAP_BTN3 = 0;
    set_alarm(7, 0);
    set_time(6, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    check_out("reset", 0, 0, 0);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1;

    // on set hit b2 b3 en khz e05 | alarm snooze buzzer
    tbl.push_back('{1,0,0,0,0,0,0,0, 0,0,0});
    tbl.push_back('{1,1,1,0,0,0,0,0, 0,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0, 0,0,0});
    tbl.push_back('{0,0,1,0,0,0,0,0, 0,0,0});
    tbl.push_back('{1,0,0,1,1,0,0,0, 0,0,0});
    tbl.push_back('{1,0,1,0,0,0,0,0, 1,0,0});
    tbl.push_back('{1,0,1,0,0,0,1,1, 1,0,1});
    tbl.push_back('{1,0,1,0,0,0,0,1, 1,0,1});
    tbl.push_back('{1,0,1,0,0,0,1,1, 1,0,0});
    tbl.push_back('{1,0,1,0,0,0,1,0, 1,0,0});
    tbl.push_back('{1,0,1,0,0,0,0,1, 1,0,1});
    tbl.push_back('{1,0,1,1,1,0,0,0, 0,0,0});
    tbl.push_back('{1,0,0,0,0,0,0,0, 0,0,0});
    tbl.push_back('{1,0,1,0,0,0,0,0, 1,0,0});
    tbl.push_back('{1,0,1,1,0,0,0,0, 0,1,0});
    tbl.push_back('{1,0,1,1,0,1,1,1, 0,1,0});
    tbl.push_back('{1,0,1,0,1,0,0,0, 0,0,0});
    tbl.push_back('{1,0,0,1,0,0,0,0, 0,0,0});
    tbl.push_back('{1,0,1,0,0,0,0,0, 1,0,0});
    tbl.push_back('{0,0,1,0,0,0,0,0, 0,0,0});
    foreach (tbl[i]) begin
      bus.ALARM_ON = tbl[i].on;
      bus.SET_MODE = tbl[i].set;
      bus.EN05     = tbl[i].e05;
      set_time(7, 0, tbl[i].hit ? 0 : 1);
      cycle(tbl[i].en, tbl[i].khz, tbl[i].b2, tbl[i].b3);
      check_out($sformatf("vec%0d", i), tbl[i].es, tbl[i].esn, tbl[i].eb);
    end
    bus.ALARM_ON = 1; bus.SET_MODE = 0; bus.EN05 = 0;

    // 06:59:59 -> 07:00:00 on a 1 Hz tick, then the full ring length with time held
    set_time(6, 59, 59);
    cycle(1, 0, 0, 0);
    set_time(7, 0, 0);
    check_out("trig_k", 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_out("trig_k1", 1, 0, 0);
    repeat (RING - 1) cycle(1, 0, 0, 0);
    check_out("ring_59", 1, 0, 0);
    cycle(1, 0, 0, 0);
    check_out("ring_60", 0, 0, 0);
    repeat (20) cycle(1, 0, 0, 0);
    check_out("no_retrig", 0, 0, 0);

    // snooze for its full length, re-ring, then stop
    retrig();
    check_out("snz_pre", 1, 0, 0);
    bus.EN05 = 1;
    cycle(0, 1, 1, 0);
    check_out("snz_enter", 0, 1, 0);
    repeat (SNOOZE - 1) cycle(1, 1, 0, 0);
    check_out("snz_299", 0, 1, 0);
    cycle(1, 0, 0, 0);
    check_out("snz_300", 1, 0, 0);
    cycle(0, 0, 0, 1);
    check_out("snz_stop", 0, 0, 0);
    bus.EN05 = 0;

    // ALARM_ON dropped on ring tick 10
    retrig();
    repeat (9) cycle(1, 0, 0, 0);
    bus.ALARM_ON = 0;
    cycle(1, 0, 0, 0);
    check_out("alarm_off", 0, 0, 0);
    bus.ALARM_ON = 1;

    // timeout tick coinciding with snooze press
    retrig();
    repeat (RING - 1) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    check_out("timeout_snz", 0, 1, 0);
    cycle(0, 0, 0, 1);
    check_out("timeout_stop", 0, 0, 0);

    // alarm at 00:00 across midnight
    set_alarm(0, 0);
    set_time(23, 59, 59);
    cycle(1, 0, 0, 0);
    set_time(0, 0, 0);
    check_out("midnight_k", 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_out("midnight_k1", 1, 0, 0);
    cycle(0, 0, 0, 1);
    set_alarm(7, 0);

    // asynchronous reset while buzzing, then a normal retrigger
    retrig();
    bus.EN05 = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0);
      if (bus.BUZZER === 1'b1) break;
    end
    check1("buzz_before_reset", bus.BUZZER, 1'b1);
    RESET = 1'b0;
    #1;
    check_out("async_reset", 0, 0, 0);
    set_time(7, 0, 1);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1;
    set_time(7, 0, 0);
    cycle(0, 0, 0, 0);
    check_out("post_reset_trig", 1, 0, 0);
    cycle(0, 0, 0, 1);

    // randomized run against the behavioural model
    RESET = 1'b0;
    set_alarm(13, 45);
    set_time(0, 0, 1);
    m_ring = 0; m_snz = 0; m_prev = 0; m_buzz = 0; m_left = 0; m_tones = 0;
    @(negedge CLK) RESET = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      bus.ALARM_ON   = ($urandom % 300) != 0;
      bus.SET_MODE   = ($urandom % 50) == 0;
      bus.BAP_BTN2   = ($urandom % 150) == 0;
      bus.BAP_BTN3   = ($urandom % 400) == 0;
      bus.ENABLE     = ($urandom % 3) == 0;
      bus.ENABLE_kHz = ($urandom % 4) == 0;
      if (($urandom % 20) == 0) bus.EN05 = ~bus.EN05;
      if (($urandom % 4) != 0)
        set_time(ah, am, (($urandom % 2) != 0) ? 0 : int'($urandom_range(1, 59)));
      else
        set_time(int'($urandom % 24), int'($urandom % 60), int'($urandom % 60));
      model_step();
      @(posedge CLK); #1;
      check1($sformatf("rand%0d/alarm_state", c), bus.ALARM_STATE, m_ring);
      check1($sformatf("rand%0d/snooze_led", c),  bus.SNOOZE_LED,  m_snz);
      check1($sformatf("rand%0d/buzzer", c),      bus.BUZZER,      m_buzz);
      if (n_fail > 40) break;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
